// File: rtl/qdi2bin_1of2_rx.sv
// Clocked receiver for an enable-driven e1of2 dual-rail channel: synchronize, decode, acknowledge,
// and queue decoded bits behind a valid/ready port. Define QDI2BIN_ERRCHK_EN to build the illegal-code checker.
module qdi2bin_1of2_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int DEPTH       = 4
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic [1:0]               L,
  output logic                     Le,
  output logic                     dout,
  output logic                     dvalid,
  input  logic                     dready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err,
  inout  wire                      VDD,
  inout  wire                      GND
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    ST_NEUTRAL  = 2'd0,
    ST_FULLWAIT = 2'd1,
    ST_READY    = 2'd2
  } state_t;

  // Supplies are carried through for the netlist only.
  wire unused_supply = &{1'b0, VDD, GND};

  logic [1:0]             sync_q [SYNC_STAGES];
  logic [1:0]             sync_d [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] fill_q;
  logic [SYNC_STAGES-1:0] fill_d;
  logic [1:0]             sl;
  logic                   sl_valid;

  state_t                 state_q;
  state_t                 state_d;
  logic                   le_q;
  logic                   le_d;
  logic                   push;
  logic                   push_bit;
  logic                   pop;
  logic                   space_ok;

  logic                   mem_q [DEPTH];
  logic                   mem_d [DEPTH];
  logic [AW-1:0]          wr_ptr_q;
  logic [AW-1:0]          wr_ptr_d;
  logic [AW-1:0]          rd_ptr_q;
  logic [AW-1:0]          rd_ptr_d;
  logic [CW-1:0]          count_q;
  logic [CW-1:0]          count_d;
  logic                   dvalid_q;
  logic                   dvalid_d;
  logic                   dout_q;
  logic                   dout_d;

  // fill_q marks how far real samples have travelled since reset, so the
  // cleared flops are never mistaken for an observed neutral.
  always_comb begin
    sync_d[0] = L;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    fill_d = {fill_q[SYNC_STAGES-2:0], 1'b1};
  end

  assign sl       = sync_q[SYNC_STAGES-1];
  assign sl_valid = fill_q[SYNC_STAGES-1];

  assign pop      = dvalid_q && dready;
  assign space_ok = (count_q < CW'(DEPTH)) || pop;

  always_comb begin
    state_d  = state_q;
    push     = 1'b0;
    push_bit = sl[1];
    case (state_q)
      ST_NEUTRAL: begin
        if (sl_valid && (sl == 2'b00)) begin
          state_d = space_ok ? ST_READY : ST_FULLWAIT;
        end else begin
          state_d = ST_NEUTRAL;
        end
      end
      ST_FULLWAIT: begin
        if (space_ok) begin
          state_d = ST_READY;
        end else begin
          state_d = ST_FULLWAIT;
        end
      end
      ST_READY: begin
        if (sl_valid && (sl != 2'b00)) begin
          state_d = ST_NEUTRAL;
`ifdef QDI2BIN_ERRCHK_EN
          push    = (sl != 2'b11);
`else
          push    = 1'b1;
`endif
        end else begin
          state_d = ST_READY;
        end
      end
      default: begin
        state_d = ST_NEUTRAL;
      end
    endcase
    le_d = (state_d == ST_READY);
  end

  // READY is only entered with a free slot, so push never meets a full FIFO.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_bit;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d        = wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    dvalid_d = (count_d != CW'(0));
    dout_d   = dvalid_d ? mem_d[rd_ptr_d] : 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= 2'b00;
      end
      fill_q   <= '0;
      state_q  <= ST_NEUTRAL;
      le_q     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 1'b0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dvalid_q <= 1'b0;
      dout_q   <= 1'b0;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
      fill_q   <= fill_d;
      state_q  <= state_d;
      le_q     <= le_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dvalid_q <= dvalid_d;
      dout_q   <= dout_d;
    end
  end

`ifdef QDI2BIN_ERRCHK_EN
  logic err_q;
  logic err_d;

  // Sticky: a double-rail code in READY or NEUTRAL latches until reset.
  always_comb begin
    if (sl_valid && (sl == 2'b11) &&
        ((state_q == ST_READY) || (state_q == ST_NEUTRAL))) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign Le     = le_q;
  assign dout   = dout_q;
  assign dvalid = dvalid_q;
  assign count  = count_q;

endmodule

// File: tb/tb_qdi2bin_1of2_rx.sv
// Scoreboard bench for qdi2bin_1of2_rx: tokens are queued when driven on L and
// compared in order as they leave through the valid/ready port.
module tb_qdi2bin_1of2_rx;

  localparam int SYNC_STAGES = 2;
  localparam int DEPTH       = 4;
  localparam int CW          = $clog2(DEPTH) + 1;
  localparam int LAT         = SYNC_STAGES + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    l = 2'b00;
  logic          dready_man = 1'b0;
  logic          rand_en = 1'b0;
  logic          rand_bit = 1'b0;
  wire           dready = rand_en ? rand_bit : dready_man;
  logic          le;
  logic          dout;
  logic          dvalid;
  logic [CW-1:0] count;
  logic          err;
  wire           vdd = 1'b1;
  wire           gnd = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;
  int n_in     = 0;
  int n_out    = 0;
  bit exp_q[$];

`ifdef QDI2BIN_ERRCHK_EN
  localparam bit ERRCHK = 1'b1;
`else
  localparam bit ERRCHK = 1'b0;
`endif

  qdi2bin_1of2_rx #(.SYNC_STAGES(SYNC_STAGES), .DEPTH(DEPTH)) dut (
    .CLK    (clk),
    .RESET  (reset),
    .L      (l),
    .Le     (le),
    .dout   (dout),
    .dvalid (dvalid),
    .dready (dready),
    .count  (count),
    .err    (err),
    .VDD    (vdd),
    .GND    (gnd)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    rand_bit = 1'($urandom_range(0, 1));
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  // Handshake values are stable from the falling edge to the next rising edge.
  always @(negedge clk) begin
    if (!reset && dvalid && dready) begin
      if (exp_q.size() == 0) begin
        check_eq("extra_output_queue_size", exp_q.size(), 1);
      end else begin
        check_eq("output_order", dout, exp_q.pop_front());
      end
      n_out++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_le(input logic val, input string tag);
    for (int i = 0; i < 200 && le !== val; i++) tick();
    if (le !== val) check_eq(tag, le, val);
  endtask

  task automatic send_token(input logic [1:0] code, input bit push_exp, input bit expv);
    wait_le(1'b1, "timeout_wait_ready");
    l = code;
    if (push_exp) begin
      exp_q.push_back(expv);
      n_in++;
    end
    wait_le(1'b0, "timeout_wait_ack");
    l = 2'b00;
  endtask

  task automatic drain();
    dready_man = 1'b1;
    repeat (DEPTH + 2) tick();
    dready_man = 1'b0;
    check_eq("drain_count", count, 0);
    check_eq("drain_queue", exp_q.size(), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit seq [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    repeat (3) tick();
    check_eq("reset_le", le, 0);
    check_eq("reset_count", count, 0);
    check_eq("reset_dvalid", dvalid, 0);
    check_eq("reset_dout", dout, 0);
    check_eq("reset_err", err, 0);

    reset = 1'b0;
    repeat (LAT - 1) tick();
    check_eq("le_before_rise", le, 0);
    tick();
    check_eq("le_rise_after_reset", le, 1);

    l = 2'b01;
    exp_q.push_back(1'b0);
    n_in++;
    repeat (LAT - 1) tick();
    check_eq("le_before_ack", le, 1);
    check_eq("dvalid_before_push", dvalid, 0);
    tick();
    check_eq("le_ack", le, 0);
    check_eq("dvalid_push", dvalid, 1);
    check_eq("dout_push", dout, 0);
    check_eq("count_push", count, 1);
    l = 2'b00;
    repeat (LAT - 1) tick();
    check_eq("le_before_release", le, 0);
    tick();
    check_eq("le_release", le, 1);
    drain();

    // Fill the FIFO, then release one slot at a time.
    for (int i = 0; i < 4; i++) send_token(seq[i] ? 2'b10 : 2'b01, 1'b1, seq[i]);
    check_eq("count_full", count, DEPTH);
    repeat (LAT + 3) tick();
    check_eq("fullwait_le", le, 0);
    check_eq("fullwait_count", count, DEPTH);
    dready_man = 1'b1;
    tick();
    dready_man = 1'b0;
    check_eq("le_rise_on_pop", le, 1);
    check_eq("count_after_pop", count, DEPTH - 1);
    send_token(seq[4] ? 2'b10 : 2'b01, 1'b1, seq[4]);
    check_eq("count_fifth", count, DEPTH);

    repeat (LAT + 2) tick();
    dready_man = 1'b1;
    tick();
    dready_man = 1'b0;
    check_eq("count_before_coincide", count, DEPTH - 1);
    l = 2'b10;
    exp_q.push_back(1'b1);
    n_in++;
    repeat (LAT - 1) tick();
    dready_man = 1'b1;
    tick();
    dready_man = 1'b0;
    check_eq("push_pop_same_edge_count", count, DEPTH - 1);
    check_eq("push_pop_same_edge_le", le, 0);
    l = 2'b00;
    drain();

    // Reset in the middle of a handshake drops the token.
    wait_le(1'b1, "timeout_before_abort");
    l = 2'b10;
    repeat (LAT) tick();
    check_eq("abort_ack", le, 0);
    reset = 1'b1;
    repeat (2) tick();
    check_eq("abort_count", count, 0);
    check_eq("abort_dvalid", dvalid, 0);
    check_eq("abort_le", le, 0);
    reset = 1'b0;
    repeat (6) tick();
    check_eq("le_held_non_neutral", le, 0);
    l = 2'b00;
    repeat (LAT - 1) tick();
    check_eq("abort_le_before_rise", le, 0);
    tick();
    check_eq("abort_le_rise", le, 1);
    check_eq("abort_nothing_pushed", count, 0);

    // Illegal double-rail code.
    l = 2'b11;
    if (!ERRCHK) begin
      exp_q.push_back(1'b1);
      n_in++;
    end
    repeat (LAT) tick();
    check_eq("illegal_le", le, 0);
    check_eq("illegal_err", err, ERRCHK);
    check_eq("illegal_count", count, ERRCHK ? 0 : 1);
    check_eq("illegal_dout", dout, ERRCHK ? 0 : 1);
    l = 2'b00;
    send_token(2'b01, 1'b1, 1'b0);
    repeat (2) tick();
    check_eq("err_persist", err, ERRCHK);
    drain();

    // A second code before neutral must not be pushed again.
    send_token(2'b01, 1'b1, 1'b0);
    l = 2'b10;
    repeat (4) tick();
    check_eq("no_repush_count", count, 1);
    check_eq("no_repush_le", le, 0);
    l = 2'b00;
    drain();

    rand_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      bit b;
      b = 1'($urandom_range(0, 1));
      send_token(b ? 2'b10 : 2'b01, 1'b1, b);
      repeat ($urandom_range(0, 3)) tick();
    end
    rand_en = 1'b0;
    repeat (LAT + 1) tick();
    drain();
    check_eq("in_out_count", n_out, n_in);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
